// File: rtl/cmd_frame_tx_if.sv
// Command-decoder / TX-FIFO side signals of the command-frame packer.
// The master drives the command trigger and FIFO status; the slave (the packer) drives the write side.
interface cmd_frame_tx_if #(
  parameter int ARG_BYTES = 4
);
  logic                   finsh_i;
  logic [7:0]             cmd_i;
  logic [8*ARG_BYTES-1:0] arg_i;
  logic                   txfull;
  logic                   txen;
  logic [7:0]             dat_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   drop_o;

  // FIFO handshake: a byte transfers in every cycle where txen is high; txen is never high while txfull is high.
  modport master (
    output finsh_i, cmd_i, arg_i, txfull,
    input  txen, dat_o, busy_o, done_o, drop_o
  );

  modport slave (
    input  finsh_i, cmd_i, arg_i, txfull,
    output txen, dat_o, busy_o, done_o, drop_o
  );
endinterface

// File: rtl/cmd_frame_tx.sv
// Packs header, command, argument (MS byte first) and optional XOR checksum into a
// frame on a trigger edge of finsh_i, then writes it byte-wise into the TX FIFO.
module cmd_frame_tx #(
  parameter int         ARG_BYTES  = 4,
  parameter logic [7:0] HDR_BYTE   = 8'hF0,
  parameter bit         CHK_EN     = 1'b1,
  parameter bit         START_EDGE = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  cmd_frame_tx_if.slave  bus,
  output logic [1:0]     state_o
);

  localparam int   FLEN     = 2 + ARG_BYTES + (CHK_EN ? 1 : 0);
  localparam int   IDX_W    = $clog2(FLEN);
  localparam logic IDLE_LVL = ~START_EDGE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             fin_d;
  logic             trig;
  logic             capture;
  logic [7:0]       chk;
  logic [7:0]       frame_q [FLEN];

  assign trig    = START_EDGE ? (~fin_d & bus.finsh_i) : (fin_d & ~bus.finsh_i);
  assign capture = (state_q == IDLE) & trig;
  assign state_o = state_q;

  always_comb begin
    chk = bus.cmd_i;
    for (int i = 0; i < ARG_BYTES; i++) begin
      chk = chk ^ bus.arg_i[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    bus.txen   = 1'b0;
    bus.done_o = 1'b0;
    bus.drop_o = 1'b0;
    bus.busy_o = (state_q != IDLE);
    bus.dat_o  = 8'h00;
    case (state_q)
      IDLE: begin
        if (trig) state_d = SEND;
      end
      SEND: begin
        bus.dat_o = frame_q[idx_q];
        bus.txen  = ~bus.txfull & ~rst;
        if (bus.txen && idx_q == IDX_W'(FLEN - 1)) state_d = DONE;
      end
      DONE: begin
        bus.done_o = ~rst;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A trigger outside IDLE is reported and discarded, never queued.
    if (state_q != IDLE && trig && !rst) bus.drop_o = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fin_d   <= IDLE_LVL;
    end else begin
      state_q <= state_d;
      fin_d   <= bus.finsh_i;
      if (capture) begin
        idx_q <= '0;
      end else if (bus.txen) begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  // Frame contents need no reset: they are only read in SEND, which always follows a capture.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      frame_q[0] <= HDR_BYTE;
      frame_q[1] <= bus.cmd_i;
      for (int i = 0; i < ARG_BYTES; i++) begin
        frame_q[2+i] <= bus.arg_i[8*(ARG_BYTES-1-i) +: 8];
      end
      if (CHK_EN) frame_q[FLEN-1] <= chk;
    end
  end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Self-checking bench for cmd_frame_tx: a falling-edge/checksum instance and a
// rising-edge/no-checksum instance, each with a byte scoreboard on its FIFO side.
module tb_cmd_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cmd_frame_tx_if #(.ARG_BYTES(4)) bus0 ();
  cmd_frame_tx_if #(.ARG_BYTES(1)) bus1 ();
  logic [1:0] state0, state1;

  cmd_frame_tx #(.ARG_BYTES(4), .HDR_BYTE(8'hF0), .CHK_EN(1'b1), .START_EDGE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_o(state0)
  );
  cmd_frame_tx #(.ARG_BYTES(1), .HDR_BYTE(8'hF0), .CHK_EN(1'b0), .START_EDGE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_o(state1)
  );

  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  int wr_cnt0 = 0, done_cnt0 = 0, drop_cnt0 = 0;
  int last_done0 = -1, last_drop0 = -1;
  int wr_cnt1 = 0, done_cnt1 = 0, last_wr1 = -1, last_done1 = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus0.txfull) check("dut0_no_write_when_full", {31'd0, bus0.txen}, 32'd0);
    if (bus0.txen) begin
      wr_cnt0++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut0_unexpected_write: got %0h expected none (cycle %0d)", bus0.dat_o, cyc);
      end else begin
        check("dut0_byte", {24'd0, bus0.dat_o}, {24'd0, exp_q.pop_front()});
      end
    end
    if (bus0.done_o) begin done_cnt0++; last_done0 = cyc; end
    if (bus0.drop_o) begin drop_cnt0++; last_drop0 = cyc; end
  end

  always @(negedge clk) begin
    if (bus1.txen) begin
      wr_cnt1++;
      last_wr1 = cyc;
      if (exp1_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_write: got %0h expected none (cycle %0d)", bus1.dat_o, cyc);
      end else begin
        check("dut1_byte", {24'd0, bus1.dat_o}, {24'd0, exp1_q.pop_front()});
      end
    end
    if (bus1.done_o) begin done_cnt1++; last_done1 = cyc; end
  end

  function automatic logic [7:0] model_chk(input logic [7:0] c, input logic [31:0] a);
    return c ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0];
  endfunction

  task automatic push_frame0(input logic [7:0] c, input logic [31:0] a, input logic [7:0] k);
    exp_q.push_back(8'hF0);
    exp_q.push_back(c);
    exp_q.push_back(a[31:24]);
    exp_q.push_back(a[23:16]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(k);
  endtask

  task automatic trig0(input logic [7:0] c, input logic [31:0] a, output int t);
    bus0.cmd_i   = c;
    bus0.arg_i   = a;
    bus0.finsh_i = 1'b0;
    t = cyc;
    step();
    bus0.finsh_i = 1'b1;
  endtask

  task automatic wait_done0(input int start, input int budget);
    for (int i = 0; i < budget && done_cnt0 == start; i++) step();
    check("dut0_done_seen", done_cnt0 - start, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] arg;
    logic [7:0]  chk;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t, d0, w0, dr0;
    logic [7:0]  rc;
    logic [31:0] ra;

    vecs[0] = '{cmd: 8'h19, arg: 32'h12345678, chk: 8'h11};
    vecs[1] = '{cmd: 8'h00, arg: 32'h00000000, chk: 8'h00};
    vecs[2] = '{cmd: 8'hFF, arg: 32'hFFFFFFFF, chk: 8'hFF};
    vecs[3] = '{cmd: 8'hA5, arg: 32'h01020304, chk: 8'hA1};
    vecs[4] = '{cmd: 8'h3C, arg: 32'h80000001, chk: 8'hBD};

    bus0.finsh_i = 1'b1; bus0.cmd_i = '0; bus0.arg_i = '0; bus0.txfull = 1'b0;
    bus1.finsh_i = 1'b0; bus1.cmd_i = '0; bus1.arg_i = '0; bus1.txfull = 1'b0;

    // Reset state
    step(); step();
    @(negedge clk);
    check("rst_txen",  {31'd0, bus0.txen},   32'd0);
    check("rst_busy",  {31'd0, bus0.busy_o}, 32'd0);
    check("rst_done",  {31'd0, bus0.done_o}, 32'd0);
    check("rst_drop",  {31'd0, bus0.drop_o}, 32'd0);
    check("rst_dat",   {24'd0, bus0.dat_o},  32'd0);
    check("rst_state", {30'd0, state0},      32'd0);
    check("rst_busy1", {31'd0, bus1.busy_o}, 32'd0);
    step();
    rst = 1'b0;
    step(); step();

    // Table-driven frames, no backpressure
    foreach (vecs[i]) begin
      d0 = done_cnt0;
      push_frame0(vecs[i].cmd, vecs[i].arg, vecs[i].chk);
      trig0(vecs[i].cmd, vecs[i].arg, t);
      @(negedge clk);
      check("basic_busy_t1", {31'd0, bus0.busy_o}, 32'd1);
      wait_done0(d0, 20);
      check("basic_done_cycle", last_done0 - t, 32'd8);
      check("basic_queue_empty", exp_q.size(), 32'd0);
      step();
      check("basic_idle_after", {31'd0, bus0.busy_o}, 32'd0);
    end

    // Random frames against the checksum model
    for (int r = 0; r < 4; r++) begin
      rc = 8'($urandom_range(0, 255));
      ra = $urandom;
      d0 = done_cnt0;
      push_frame0(rc, ra, model_chk(rc, ra));
      trig0(rc, ra, t);
      wait_done0(d0, 20);
      check("rand_done_cycle", last_done0 - t, 32'd8);
      step();
    end

    // Backpressure on the first argument byte
    d0 = done_cnt0; w0 = wr_cnt0;
    push_frame0(8'h19, 32'h12345678, 8'h11);
    trig0(8'h19, 32'h12345678, t);
    step(); step();
    bus0.txfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_txen_low", {31'd0, bus0.txen}, 32'd0);
      check("bp_dat_held", {24'd0, bus0.dat_o}, 32'h12);
      step();
    end
    bus0.txfull = 1'b0;
    wait_done0(d0, 20);
    check("bp_done_cycle", last_done0 - t, 32'd11);
    check("bp_write_count", wr_cnt0 - w0, 32'd7);
    step();

    // Dropped request while sending
    d0 = done_cnt0; w0 = wr_cnt0; dr0 = drop_cnt0;
    push_frame0(8'h19, 32'h12345678, 8'h11);
    trig0(8'h19, 32'h12345678, t);
    step(); step();
    bus0.cmd_i   = 8'h0D;
    bus0.finsh_i = 1'b0;
    @(negedge clk);
    check("drop_pulse", {31'd0, bus0.drop_o}, 32'd1);
    step();
    bus0.finsh_i = 1'b1;
    wait_done0(d0, 20);
    check("drop_count", drop_cnt0 - dr0, 32'd1);
    check("drop_cycle", last_drop0 - t, 32'd3);
    check("drop_done_cycle", last_done0 - t, 32'd8);
    for (int i = 0; i < 10; i++) step();
    check("drop_no_second_frame", wr_cnt0 - w0, 32'd7);
    check("drop_single_done", done_cnt0 - d0, 32'd1);

    // Reset mid-frame
    d0 = done_cnt0;
    push_frame0(8'h19, 32'h12345678, 8'h11);
    trig0(8'h19, 32'h12345678, t);
    step(); step();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_txen", {31'd0, bus0.txen}, 32'd0);
    check("rstmid_two_written", exp_q.size(), 32'd5);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", {31'd0, bus0.busy_o}, 32'd0);
    exp_q.delete();
    w0 = wr_cnt0;
    for (int i = 0; i < 10; i++) step();
    check("rstmid_no_writes", wr_cnt0 - w0, 32'd0);
    check("rstmid_no_done", done_cnt0 - d0, 32'd0);
    push_frame0(8'h2A, 32'hCAFEBABE, model_chk(8'h2A, 32'hCAFEBABE));
    trig0(8'h2A, 32'hCAFEBABE, t);
    wait_done0(d0, 20);
    check("rstmid_fresh_done_cycle", last_done0 - t, 32'd8);
    step();

    // FIFO full at trigger time
    d0 = done_cnt0;
    bus0.txfull = 1'b1;
    push_frame0(8'h19, 32'h12345678, 8'h11);
    trig0(8'h19, 32'h12345678, t);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_busy", {31'd0, bus0.busy_o}, 32'd1);
      check("full_txen_low", {31'd0, bus0.txen}, 32'd0);
      check("full_state_send", {30'd0, state0}, 32'd1);
      step();
    end
    bus0.txfull = 1'b0;
    @(negedge clk);
    check("full_first_txen", {31'd0, bus0.txen}, 32'd1);
    check("full_first_dat", {24'd0, bus0.dat_o}, 32'hF0);
    wait_done0(d0, 20);
    check("full_done_cycle", last_done0 - t, 32'd12);
    step();

    // Rising-edge instance, one argument byte, no checksum
    exp1_q.push_back(8'hF0);
    exp1_q.push_back(8'h05);
    exp1_q.push_back(8'hA5);
    bus1.cmd_i = 8'h05;
    bus1.arg_i = 8'hA5;
    bus1.finsh_i = 1'b1;
    t = cyc;
    step();
    for (int i = 0; i < 20 && done_cnt1 == 0; i++) step();
    check("rise_done_seen", done_cnt1, 32'd1);
    check("rise_write_count", wr_cnt1, 32'd3);
    check("rise_last_write_cycle", last_wr1 - t, 32'd3);
    check("rise_done_cycle", last_done1 - t, 32'd4);
    check("rise_queue_empty", exp1_q.size(), 32'd0);
    bus1.finsh_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("fall_ignored_busy", {31'd0, bus1.busy_o}, 32'd0);
      step();
    end
    check("fall_ignored_writes", wr_cnt1, 32'd3);
    check("fall_ignored_done", done_cnt1, 32'd1);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait is ever left unbounded.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmd_frame_tx.md
Name: cmd_frame_tx

Overview:
- Parametrised command-frame packer between the command decoder and the byte-wide TX FIFO of the SDIO/SPI bridge.
- On a trigger edge of `finsh_i`, it snapshots the command byte and argument and builds a frame: header byte, command byte, argument bytes MSB first, then an optional XOR checksum.
- It then writes the frame one byte per FIFO write strobe, honouring `txfull` on every byte.
- Successor block: adds configurable argument width, header value, trigger polarity and checksum, plus per-byte backpressure, busy/done status and dropped-request reporting.

Parameters:
- ARG_BYTES, 4: number of argument bytes in the frame (1..8); `arg_i` width is 8*ARG_BYTES.
- HDR_BYTE, 8'hF0: first byte of every frame.
- CHK_EN, 1: 1 appends a checksum byte (XOR of cmd and all arg bytes, header excluded); 0 omits it.
- START_EDGE, 0: 0 triggers on a falling edge of `finsh_i`; 1 triggers on a rising edge.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `finsh_i`  in  1  command-complete level; its selected edge starts a frame.
- `cmd_i`  in  8  command byte, sampled in the trigger cycle.
- `arg_i`  in  8*ARG_BYTES  argument, sampled in the trigger cycle; the MS byte is sent first.
- `txfull`  in  1  TX FIFO full (active-high); no write may occur while it is high.
- `txen`  out  1  FIFO write strobe; one byte is written per cycle in which it is high.
- `dat_o`  out  8  byte presented with `txen`.
- `busy_o`  out  1  high from the cycle after the trigger until the frame completes.
- `done_o`  out  1  one-cycle pulse after the last byte is written.
- `drop_o`  out  1  one-cycle pulse when a trigger arrives while not IDLE.

Behaviour:
- Frame length: FLEN = 2 + ARG_BYTES + CHK_EN bytes.
- Byte order:
  - byte 0 = HDR_BYTE
  - byte 1 = `cmd_i`
  - bytes 2..ARG_BYTES+1 = `arg_i` bytes, MSB first
  - last byte = checksum, only if CHK_EN = 1
- Edge detect:
  - `fin_d` <= `finsh_i` every cycle; reset value = the idle level (1 if START_EDGE = 0, else 0).
  - trig = `fin_d` & ~`finsh_i` when START_EDGE = 0; ~`fin_d` & `finsh_i` when START_EDGE = 1.
  - trig is combinational on the current input.
- State machine states: IDLE, SEND, DONE.
- IDLE:
  - On trig in cycle T: capture `cmd_i`, `arg_i` and the checksum into the frame register, clear the byte index to 0, and go to SEND at T+1.
  - `txfull` is not checked at trigger time.
- SEND:
  - `txen` = (state == SEND) & ~`txfull` & ~`rst`. This is combinational, so the FIFO sees a write only in cycles where it is not full.
  - `dat_o` = frame byte at the current index; it is valid throughout SEND and stable while `txen` is low.
  - The index increments only in cycles where `txen` = 1.
  - Writing byte FLEN-1 moves the block to DONE.
  - Back-to-back writes are required: with `txfull` low throughout, the bytes go out in cycles T+1 .. T+FLEN.
- DONE: `done_o` = 1 for exactly one cycle, then return to IDLE. A new trigger is accepted from the following cycle onwards.
- `busy_o` = (state != IDLE).
- Triggers in SEND or DONE:
  - `drop_o` pulses in the trig cycle.
  - Frame contents are unchanged and the trigger is not queued.
- Backpressure: any number of cycles of `txfull` = 1 holds the index and `dat_o`. No byte may be lost, duplicated or reordered.
- Reset:
  - On `rst` = 1 (sampled at a clock edge): state = IDLE, index = 0, `fin_d` = idle level, `dat_o` = 8'h00, `busy_o` = 0, `done_o` = 0, `drop_o` = 0.
  - `txen` is 0 during any cycle in which `rst` is high.
  - Reset mid-frame aborts the frame: no further bytes are written and no `done_o` is produced.
- Checksum width: 8 bits, computed once at capture and never updated mid-frame.

Test Plan:
- Basic frame (ARG_BYTES=4, CHK_EN=1, START_EDGE=0): `cmd_i` = 8'h19, `arg_i` = 32'h12345678, `finsh_i` 1->0 at T, `txfull` = 0.
  - Required: `txen` high T+1..T+7 with `dat_o` = F0, 19, 12, 34, 56, 78, 11.
  - Required: `done_o` at T+8; `busy_o` high T+1..T+8.
- Backpressure, same frame: `txfull` = 1 for 3 cycles starting when byte 8'h12 is due.
  - Required: `txen` low for those 3 cycles with `dat_o` held at 8'h12.
  - Required: 7 bytes total, unchanged order; `done_o` at T+11.
- Dropped request: second falling edge of `finsh_i` at T+3 with a different cmd (8'h0D).
  - Required: `drop_o` pulse at T+3; only the original 7-byte frame is written; no second frame.
- Rising-edge mode (START_EDGE=1, ARG_BYTES=1, CHK_EN=0): `cmd_i` = 8'h05, `arg_i` = 8'hA5, `finsh_i` 0->1.
  - Required: `dat_o` = F0, 05, A5 in 3 consecutive writes, then `done_o`.
  - Required: a 1->0 transition produces nothing.
- Reset mid-frame: assert `rst` for 1 cycle after the 2nd byte is written.
  - Required: `txen` = 0 from the reset cycle, `busy_o` = 0, no `done_o`.
  - Required: the next falling edge produces a full fresh frame starting with F0.
- Full FIFO at trigger: `txfull` = 1 at T and stays high for 5 cycles.
  - Required: `busy_o` rises at T+1 with no writes; first F0 is written in the first cycle `txfull` = 0.
